// File: rtl/canny3_sobel.sv
// Canny stage 3: 3x3 Sobel gradient over the filtered pixel stream.
// Emits a saturated magnitude and a 2-bit quantised direction, with syncs delayed to match.
module canny3_sobel #(
  parameter int IMG_W     = 1024,
  parameter int MAG_SHIFT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gaus_de,
  input  logic       gaus_hs,
  input  logic       gaus_vs,
  input  logic [7:0] gaus_oData,
  output logic       sobel_de,
  output logic       sobel_hs,
  output logic       sobel_vs,
  output logic [7:0] sobel_mag,
  output logic [1:0] sobel_dir
);

  localparam int AW  = (IMG_W > 2) ? $clog2(IMG_W) : 2;
  localparam int LAT = 5;

  logic [AW-1:0]  col_cnt, wr_addr;
  logic [1:0]     row_cnt;
  logic           de_prev, vs_prev;
  logic [LAT-1:0] de_sr, hs_sr, vs_sr;

  logic [7:0] lb1 [0:IMG_W-1];
  logic [7:0] lb2 [0:IMG_W-1];

  logic [7:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic       mask_c1, mask_c2, mask_c3, mask_c4;
  logic [9:0] gx_p, gx_n, gy_p, gy_n;
  logic signed [10:0] gx, gy;
  logic [10:0] mag_c4;
  logic [1:0]  dir_c4;

  // Counters and edge detectors for de/vs
  always_ff @(posedge clk) begin
    if (rst) begin
      col_cnt <= '0;
      wr_addr <= '0;
      row_cnt <= 2'd0;
      de_prev <= 1'b0;
      vs_prev <= 1'b0;
    end else begin
      de_prev <= gaus_de;
      vs_prev <= gaus_vs;
      if (gaus_de) begin
        wr_addr <= col_cnt;
        col_cnt <= (col_cnt == AW'(IMG_W - 1)) ? '0 : col_cnt + 1'b1;
      end else begin
        col_cnt <= '0;
      end
      if (gaus_vs && !vs_prev)
        row_cnt <= 2'd0;
      else if (!gaus_de && de_prev && row_cnt != 2'd2)
        row_cnt <= row_cnt + 2'd1;
    end
  end

  // Line buffers: lb2 takes the lb1 read-out one cycle later (held in a6), so both RAMs
  // need only a single registered read port.
  always_ff @(posedge clk) begin
    if (!rst && gaus_de)
      lb1[col_cnt] <= gaus_oData;
    if (!rst && de_prev)
      lb2[wr_addr] <= a6;
  end

  // c1: window register, shifts left on each valid pixel
  always_ff @(posedge clk) begin
    if (rst) begin
      {a1, a2, a3, a4, a5, a6, a7, a8, a9} <= '0;
      mask_c1 <= 1'b0;
    end else if (gaus_de) begin
      a1 <= a2; a2 <= a3; a3 <= lb2[col_cnt];
      a4 <= a5; a5 <= a6; a6 <= lb1[col_cnt];
      a7 <= a8; a8 <= a9; a9 <= gaus_oData;
      mask_c1 <= (row_cnt < 2'd2) || (col_cnt < AW'(2));
    end
  end

  // c4 combinational helpers: absolute values and direction compares
  logic [10:0] gx_neg, gy_neg, ax, ay, mag_w, mag_sh;
  logic [12:0] ax2, ax5, ay2, ay5;
  logic [1:0]  dir_w;
  logic [7:0]  mag_sat;

  always_comb begin
    gx_neg = 11'(-gx);
    gy_neg = 11'(-gy);
    ax     = gx[10] ? gx_neg : 11'(gx);
    ay     = gy[10] ? gy_neg : 11'(gy);
    mag_w  = ax + ay;
    ax2    = {1'b0, ax, 1'b0};
    ay2    = {1'b0, ay, 1'b0};
    ax5    = {2'b00, ax} + {ax, 2'b00};
    ay5    = {2'b00, ay} + {ay, 2'b00};
    dir_w  = 2'd0;
    if (ax == 11'd0 && ay == 11'd0)
      dir_w = 2'd0;
    else if (ay5 < ax2)
      dir_w = 2'd0;
    else if (ay2 > ax5)
      dir_w = 2'd2;
    else if (gx[10] == gy[10])
      dir_w = 2'd1;
    else
      dir_w = 2'd3;
    mag_sh  = mag_c4 >> MAG_SHIFT;
    mag_sat = (mag_sh > 11'd255) ? 8'hFF : mag_sh[7:0];
  end

  // c2..c5 arithmetic pipeline plus sync delay lines
  always_ff @(posedge clk) begin
    if (rst) begin
      gx_p <= '0; gx_n <= '0; gy_p <= '0; gy_n <= '0;
      gx <= '0; gy <= '0;
      mag_c4 <= '0; dir_c4 <= '0;
      mask_c2 <= 1'b0; mask_c3 <= 1'b0; mask_c4 <= 1'b0;
      sobel_mag <= '0; sobel_dir <= '0;
      de_sr <= '0; hs_sr <= '0; vs_sr <= '0;
    end else begin
      gx_p <= {2'b00, a3} + {1'b0, a6, 1'b0} + {2'b00, a9};
      gx_n <= {2'b00, a1} + {1'b0, a4, 1'b0} + {2'b00, a7};
      gy_p <= {2'b00, a7} + {1'b0, a8, 1'b0} + {2'b00, a9};
      gy_n <= {2'b00, a1} + {1'b0, a2, 1'b0} + {2'b00, a3};
      mask_c2 <= mask_c1;
      gx <= $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
      gy <= $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
      mask_c3 <= mask_c2;
      mag_c4  <= mag_w;
      dir_c4  <= dir_w;
      mask_c4 <= mask_c3;
      sobel_mag <= mask_c4 ? 8'd0 : mag_sat;
      sobel_dir <= mask_c4 ? 2'd0 : dir_c4;
      de_sr <= {de_sr[LAT-2:0], gaus_de};
      hs_sr <= {hs_sr[LAT-2:0], gaus_hs};
      vs_sr <= {vs_sr[LAT-2:0], gaus_vs};
    end
  end

  assign sobel_de = de_sr[LAT-1];
  assign sobel_hs = hs_sr[LAT-1];
  assign sobel_vs = vs_sr[LAT-1];

endmodule
